// File: rtl/ahb_mux_pkg.sv
// ---------------------------------------------------------------------------
// ahb_mux_pkg
//   Shared AHB-Lite encodings for the read-data / response multiplexer:
//   transfer types, response codes and the default-slave state encoding.
// ---------------------------------------------------------------------------
package ahb_mux_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_e;

  // NONSEQ and SEQ are the only transfer types that demand a real response.
  function automatic logic is_active(input logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// ---------------------------------------------------------------------------
// ahb_default_slave
//   Built-in slave for unmapped addresses. An accepted active transfer with
//   no owning slave produces the two-cycle AHB ERROR response
//   (ERR1: hready=0/hresp=1, ERR2: hready=1/hresp=1). Otherwise it answers
//   with a zero-wait OKAY.
//
// Ports
//   hclk         bus clock
//   hresetn      synchronous active-low reset
//   hready_i     bus-wide HREADY (address phase accepted when 1)
//   start_err_i  accepted address phase is unmapped and active
//   hready_o     default-slave HREADYOUT
//   hresp_o      default-slave HRESP
// ---------------------------------------------------------------------------
module ahb_default_slave
  import ahb_mux_pkg::*;
(
  input  logic hclk,
  input  logic hresetn,
  input  logic hready_i,
  input  logic start_err_i,
  output logic hready_o,
  output logic hresp_o
);

  ds_state_e state_q, state_d;
  logic      hready_q;
  logic      hresp_q;

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    if (state_q == DS_ERR1) begin
      // ERR1 always completes into ERR2, regardless of the bus.
      state_d = DS_ERR2;
    end else if (hready_i) begin
      state_d = start_err_i ? DS_ERR1 : DS_IDLE;
    end
  end

  // Outputs are registered alongside the state, decoded from the next state,
  // so they are identical to a decode of state_q without a combinational path.
  always_ff @(posedge hclk) begin
    // NOTE: synchronous reset lives inside the clocked block; abort any ERROR.
    if (!hresetn) begin
      state_q  <= DS_IDLE;
      hready_q <= 1'b1;
      hresp_q  <= HRESP_OKAY;
    end else begin
      // NOTE: non-blocking assignments for all sequential state.
      state_q  <= state_d;
      hready_q <= (state_d != DS_ERR1);
      hresp_q  <= (state_d != DS_IDLE) ? HRESP_ERROR : HRESP_OKAY;
    end
  end

  assign hready_o = hready_q;
  assign hresp_o  = hresp_q;

endmodule

// File: rtl/ahb_rdata_mux.sv
// ---------------------------------------------------------------------------
// ahb_rdata_mux
//   AHB-Lite slave-to-master response multiplexer. The decoder's one-hot
//   hsel is captured at each accepted address phase (hready=1) and steers
//   the owning slave's hrdata/hreadyout/hresp to the master during the data
//   phase. Unmapped active transfers are answered by ahb_default_slave.
//   hready is the bus-wide HREADY fed back to all slaves and the master.
//
// Configuration macro: AHB_RDATA_MUX_ONEHOT_CHECK_EN
//   defined   - multi-hot hsel is treated as unmapped; simulation assertion
//   undefined - lowest-index set bit of hsel wins
//
// Ports
//   hclk, hresetn  clock, synchronous active-low reset
//   hsel           one-hot address-phase select (all-zero = unmapped)
//   htrans         master transfer type
//   hrdata_s       packed slave read data, slave i at [i*DATA_WIDTH +: DATA_WIDTH]
//   hreadyout_s    per-slave HREADYOUT
//   hresp_s        per-slave HRESP
//   hrdata         read data to master
//   hready         bus HREADY
//   hresp          response to master
// ---------------------------------------------------------------------------
module ahb_rdata_mux
  import ahb_mux_pkg::*;
#(
  parameter int NUM_SLAVES = 3,
  parameter int DATA_WIDTH = 32
) (
  input  logic                             hclk,
  input  logic                             hresetn,
  input  logic [NUM_SLAVES-1:0]            hsel,
  input  logic [1:0]                       htrans,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] hrdata_s,
  input  logic [NUM_SLAVES-1:0]            hreadyout_s,
  input  logic [NUM_SLAVES-1:0]            hresp_s,
  output logic [DATA_WIDTH-1:0]            hrdata,
  output logic                             hready,
  output logic                             hresp
);

  logic [NUM_SLAVES-1:0] dsel_q, dsel_d;
  logic [NUM_SLAVES-1:0] sel_eff;
  logic                  start_err;
  logic                  ds_hready;
  logic                  ds_hresp;

`ifdef AHB_RDATA_MUX_ONEHOT_CHECK_EN
  logic multi_hot;
  // x & (x-1) clears the lowest set bit; anything left means >1 bit set.
  assign multi_hot = |(hsel & (hsel - NUM_SLAVES'(1)));
  assign sel_eff   = multi_hot ? '0 : hsel;

`ifndef SYNTHESIS
  a_hsel_onehot : assert property (@(posedge hclk) disable iff (!hresetn)
    hready |-> $onehot0(hsel))
    else $error("ahb_rdata_mux: multi-hot hsel %b", hsel);
`endif
`else
  // Two's-complement trick isolates the lowest set bit of hsel.
  assign sel_eff = hsel & (~hsel + NUM_SLAVES'(1));
`endif

  assign start_err = (sel_eff == '0) && is_active(htrans);

  // Owner changes only when the bus accepts a new address phase.
  assign dsel_d = hready ? sel_eff : dsel_q;

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      dsel_q <= '0;
    end else begin
      dsel_q <= dsel_d;
    end
  end

  ahb_default_slave u_default_slave (
    .hclk        (hclk),
    .hresetn     (hresetn),
    .hready_i    (hready),
    .start_err_i (start_err),
    .hready_o    (ds_hready),
    .hresp_o     (ds_hresp)
  );

  // dsel_q is one-hot or zero; with zero the default slave answers.
  always_comb begin
    hrdata = '0;
    hready = ds_hready;
    hresp  = ds_hresp;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (dsel_q[i]) begin
        hrdata = hrdata_s[i*DATA_WIDTH +: DATA_WIDTH];
        hready = hreadyout_s[i];
        hresp  = hresp_s[i];
      end
    end
  end

endmodule
